// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit FND time-multiplex scan with per-slot blanking.
// Optional leading-zero suppression via FND_ZERO_BLANK_EN.
module fnd_scan_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
`ifdef FND_ZERO_BLANK_EN
    input  logic [15:0] i_digits,
`endif
    output logic [1:0]  o_sel,
    output logic [3:0]  o_com,
    output logic        o_frame_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLAST =
        (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sel_n;
    logic [3:0]    com_q, com_n;
    logic          tick_n;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            o_sel        <= 2'd0;
            com_q        <= 4'b1111;
            o_frame_tick <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            o_sel        <= sel_n;
            com_q        <= com_n;
            o_frame_tick <= tick_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = o_sel;
        if (!i_enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            sel_n   = 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_n   = '0;
                    sel_n   = 2'd0;
                    state_n = (BLANK_CYCLES > 0) ? BLANK : ON;
                end
                BLANK: begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == BLAST) state_n = ON;
                end
                ON: begin
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        sel_n   = o_sel + 2'd1;
                        state_n = (BLANK_CYCLES > 0) ? BLANK : ON;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    sel_n   = 2'd0;
                end
            endcase
        end
    end

    // Outputs are derived from next-state values so sel and com move together.
    always_comb begin
        com_n  = 4'b1111;
        tick_n = 1'b0;
        if (state_n == ON) begin
            com_n  = ~(4'b0001 << sel_n);
            tick_n = (cnt_n == LAST) && (sel_n == 2'd3);
        end
    end

`ifdef FND_ZERO_BLANK_EN
    logic z3, z2, z1;
    assign z3    = (i_digits[15:12] == 4'd0);
    assign z2    = z3 && (i_digits[11:8] == 4'd0);
    assign z1    = z2 && (i_digits[7:4] == 4'd0);
    assign o_com = com_q | {z3, z2, z1, 1'b0};
`else
    assign o_com = com_q;
`endif

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: vector table, hand sequences and random enable/reset
// traffic checked against a slot-arithmetic reference model.
module tb_fnd_scan_ctrl;

    localparam int TD  = 8;
    localparam int BCA = 2;
    localparam int BCB = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [1:0]  sel_a, sel_b;
    logic [3:0]  com_a, com_b;
    logic        ft_a, ft_b;

    int total = 0;
    int bad   = 0;
    int n     = -1;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BCA)) u_a (
        .i_clk(clk), .i_reset(rst), .i_enable(en),
`ifdef FND_ZERO_BLANK_EN
        .i_digits(digits),
`endif
        .o_sel(sel_a), .o_com(com_a), .o_frame_tick(ft_a)
    );

    fnd_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BCB)) u_b (
        .i_clk(clk), .i_reset(rst), .i_enable(en),
`ifdef FND_ZERO_BLANK_EN
        .i_digits(digits),
`endif
        .o_sel(sel_b), .o_com(com_b), .o_frame_tick(ft_b)
    );

    // n = cycles since the enabling edge; -1 while parked
    always @(posedge clk) begin
        if (rst || !en) n <= -1;
        else            n <= n + 1;
    end

    function automatic bit dark(logic [15:0] d, int s);
`ifdef FND_ZERO_BLANK_EN
        return (s > 0) && ((d >> (4 * s)) == 16'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model(input int t, input int bc,
                                  output logic [1:0] s, output logic [3:0] c,
                                  output logic f);
        int slot, pos;
        s = 2'd0;
        c = 4'b1111;
        f = 1'b0;
        if (t >= 0) begin
            slot = t / TD;
            pos  = t % TD;
            s    = 2'(slot % 4);
            if (pos >= bc && !dark(digits, slot % 4)) c[slot % 4] = 1'b0;
            f = (pos == TD - 1) && (slot % 4 == 3);
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] es;
        logic [3:0] ec;
        logic       ef;
        if (chk_on) begin
            model(n, BCA, es, ec, ef);
            chk("a_sel", 32'(sel_a), 32'(es));
            chk("a_com", 32'(com_a), 32'(ec));
            chk("a_tick", 32'(ft_a), 32'(ef));
            chk("a_onehot", 32'($countones(~com_a) <= 1), 32'd1);
            model(n, BCB, es, ec, ef);
            chk("b_sel", 32'(sel_b), 32'(es));
            chk("b_com", 32'(com_b), 32'(ec));
            chk("b_tick", 32'(ft_b), 32'(ef));
            chk("b_onehot", 32'($countones(~com_b) <= 1), 32'd1);
        end
    end

    typedef struct {
        logic       rst;
        logic       en;
        int         cyc;
        logic [1:0] sel;
        logic [3:0] com;
        logic       ft;
    } vec_t;

    vec_t tbl[22];

    initial begin
        logic [3:0] zexp[3][4];
        logic [15:0] zval[3];

        tbl[0]  = '{1'b1, 1'b0, 2,   2'd0, 4'hF, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 5,   2'd0, 4'hF, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1,   2'd0, 4'hF, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1,   2'd0, 4'hF, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1,   2'd0, 4'hE, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 5,   2'd0, 4'hE, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1,   2'd1, 4'hF, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2,   2'd1, 4'hD, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8,   2'd2, 4'hB, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8,   2'd3, 4'h7, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 5,   2'd3, 4'h7, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1,   2'd0, 4'hF, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 19,  2'd2, 4'hB, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1,   2'd0, 4'hF, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 2,   2'd0, 4'hF, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1,   2'd0, 4'hE, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 6,   2'd1, 4'hF, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1,   2'd0, 4'hF, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 1,   2'd0, 4'hF, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 2,   2'd0, 4'hE, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 1,   2'd0, 4'hF, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 100, 2'd0, 4'hF, 1'b0};

        rst    = 1'b1;
        en     = 1'b0;
        digits = 16'h1000;
        @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;

        for (int i = 0; i < 22; i++) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            repeat (tbl[i].cyc) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_sel", i), 32'(sel_a), 32'(tbl[i].sel));
            chk($sformatf("vec%0d_com", i), 32'(com_a), 32'(tbl[i].com));
            chk($sformatf("vec%0d_tick", i), 32'(ft_a), 32'(tbl[i].ft));
        end

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("nob_lit", 32'(com_b != 4'hF), 32'd1);
            chk("nob_sel", 32'(sel_b), 32'((i / TD) % 4));
        end

`ifdef FND_ZERO_BLANK_EN
        zval[0] = 16'h0042;
        zval[1] = 16'h0000;
        zval[2] = 16'h1000;
        zexp[0] = '{4'hE, 4'hD, 4'hF, 4'hF};
        zexp[1] = '{4'hE, 4'hF, 4'hF, 4'hF};
        zexp[2] = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int v = 0; v < 3; v++) begin
            rst = 1'b1;
            @(negedge clk);
            digits = zval[v];
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            en  = 1'b1;
            repeat (3) @(posedge clk);
            for (int d = 0; d < 4; d++) begin
                @(negedge clk);
                chk($sformatf("zb%0d_d%0d", v, d), 32'(com_a), 32'(zexp[v][d]));
                repeat (TD) @(posedge clk);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        digits = 16'h1000;
        @(posedge clk);
        @(negedge clk);
`else
        zval[0] = 16'h0;
        zexp[0] = '{4'h0, 4'h0, 4'h0, 4'h0};
`endif

        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            rst = ($urandom_range(0, 399) == 0);
            @(posedge clk);
            @(negedge clk);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit FND (7-segment) display.
- Drives the 2-bit select of the 4:1 digit mux.
- Drives the active-low common (anode/cathode-enable) lines so that exactly one digit is lit at a time.
- Inserts a blanking interval at every digit change to suppress ghosting.
- Sits between the counter/BCD datapath and the mux + segment decoder at the top of the display path.

Parameters:
TICK_DIV, 100000, clock cycles per digit slot (100 MHz → 1 kHz per digit, 250 Hz frame); legal range ≥ 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all commons off; legal range 0 ≤ BLANK_CYCLES < TICK_DIV

Ports:
i_clk  input  1  system clock; all logic on its rising edge
i_reset  input  1  synchronous, active-high reset
i_enable  input  1  1 = scan running; 0 = display dark, scan parked
o_sel  output  2  digit select to mux; 0 = rightmost digit
o_com  output  4  active-low digit commons; bit n low = digit n lit
o_frame_tick  output  1  one-cycle pulse on the last cycle of digit 3's slot

Behaviour:
Reset and idle:
- Reset (sampled at a clock edge): state = IDLE, slot counter = 0, o_sel = 2'b00, o_com = 4'b1111, o_frame_tick = 0.
- Reset has priority over every other input, including mid-slot and mid-blank.

Slot counter:
- Width = $clog2(TICK_DIV).
- Counts 0..TICK_DIV-1 while state ≠ IDLE, then wraps to 0.
- o_sel increments by one (mod 4, 3 → 0) on each wrap.

State machine (all outputs registered):
- IDLE: o_com = 1111, o_sel = 0, counter = 0.
  - i_enable = 1 → BLANK if BLANK_CYCLES > 0, else ON.
- BLANK: o_com = 1111.
  - When counter == BLANK_CYCLES-1 → ON.
- ON: o_com = ~(4'b0001 << o_sel).
  - When counter == TICK_DIV-1: advance o_sel and go to BLANK (or stay ON, with the new o_sel, if BLANK_CYCLES == 0).

Timing:
- o_sel and o_com change on the same edge, so o_com is never low for a stale select.
- Latency: i_enable sampled high at edge k → first common goes low at edge k + BLANK_CYCLES (digit 0).
- Each digit is lit for TICK_DIV - BLANK_CYCLES cycles per slot.

o_frame_tick:
- High for exactly the cycle in which counter == TICK_DIV-1 and o_sel == 3 (state ON).
- Never high in IDLE.

i_enable deasserted in any state:
- Next edge: IDLE, o_com = 1111, o_sel = 0, counter = 0.
- Re-enable always restarts at digit 0 with a full blank.

Invariants:
- At most one o_com bit is low in any cycle.
- o_com is all-ones throughout BLANK.

Optional Feature:
Macro FND_ZERO_BLANK_EN.
- Defined:
  - Adds input i_digits [15:0]: four BCD nibbles, digit n = i_digits[4n+3:4n], sampled combinationally each cycle.
  - In ON, digit n (n = 3, 2, 1) keeps its common high if its nibble and all higher nibbles are 0 (leading-zero suppression).
  - Digit 0 is never suppressed.
  - Sequencing, o_sel and o_frame_tick are unchanged.
- Undefined: port absent; every digit is lit in its ON window.

Test Plan:
(Use TICK_DIV=8, BLANK_CYCLES=2 unless stated.)
1. Reset, then i_enable=1 held → o_com=1111 for 2 cycles; then 1110 for 6 cycles (o_sel=0); 1111 ×2, 1101 ×6 (sel=1); then 1011 and 0111 in the same pattern. o_frame_tick pulses on the 8th cycle of digit 3 (period 32 cycles). Check one-hot-low every cycle.
2. BLANK_CYCLES=0 → o_com never 1111 while enabled; o_sel steps every 8 cycles 0→1→2→3→0.
3. Drop i_enable in the middle of digit 2's ON window → next cycle o_com=1111, o_sel=0. Re-enable → 2 blank cycles, then digit 0.
4. Assert i_reset for 1 cycle during digit 1's BLANK with i_enable=1 → next cycle o_sel=0, o_com=1111, o_frame_tick=0. Scan restarts from digit 0 after the blank.
5. Hold i_enable=0 for 100 cycles after reset → o_com=1111, o_sel=0, o_frame_tick=0 throughout.
6. FND_ZERO_BLANK_EN defined:
   - i_digits=16'h0042 → digits 3 and 2 stay dark; digits 1 and 0 light.
   - i_digits=16'h0000 → only digit 0 lights.
   - i_digits=16'h1000 → all four digits light.
